mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Parametrised load/store access unit for the MEM stage of the pipelined CPU. Successor to the combinational load-extend logic.
- Accepts one access per handshake and checks alignment. Raises AdEL/AdES for misaligned accesses and DBE when the memory acknowledge times out.
- Drives a word-aligned memory port with byte enables and lane-replicated store data. Returns loads extended to DATA_W.
- Sits between the EX/MEM pipeline register and data memory. Exception outputs feed the CP0/interrupt logic.

Parameters:
DATA_W, 32, data path width in bits; 32 or 64 only.
ADDR_W, 32, byte address width.
TIMEOUT, 16, max cycles waiting for mem_ack before DBE; range 1..255.

Ports:
clk  in  1  clock, rising edge.
rstn  in  1  asynchronous active-low reset.
req_valid  in  1  access request.
req_ready  out  1  unit can accept a request.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  0 byte, 1 half, 2 word, 3 doubleword (legal only when DATA_W=64).
req_signed  in  1  sign-extend load result.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data, right-aligned.
flush  in  1  pipeline flush from the interrupt/exception logic.
rsp_valid  out  1  access completed, one-cycle pulse.
rsp_rdata  out  DATA_W  extended load data; 0 for stores.
exc_valid  out  1  exception pulse.
exc_code  out  5  4 AdEL, 5 AdES, 7 DBE.
exc_badvaddr  out  ADDR_W  faulting address.
mem_req  out  1  memory request, held until mem_ack.
mem_we  out  1  write strobe.
mem_addr  out  ADDR_W  address with low log2(DATA_W/8) bits zero.
mem_be  out  DATA_W/8  byte enables.
mem_wdata  out  DATA_W  store data replicated across lanes.
mem_ack  in  1  memory done; mem_rdata valid for loads.
mem_rdata  in  DATA_W  read data.

Behaviour:
- Reset (rstn low, async): state IDLE, timeout counter 0. All outputs 0 except req_ready=1.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = !flush.
  - An accept is req_valid && req_ready. The unit registers we, size, signed, addr and wdata.
  - Misalignment check: addr mod 2^size != 0, or size=3 with DATA_W=32. On a misaligned accept: next cycle exc_valid=1, exc_code = we ? 5 : 4, exc_badvaddr = addr. No mem_req is issued. The unit stays in IDLE.
  - On an aligned accept: go to ACCESS.
- ACCESS:
  - mem_req=1 and mem_we=we. mem_addr, mem_be and mem_wdata are registered and stable until ack.
  - mem_be has 2^size contiguous ones starting at lane addr[log2(DATA_W/8)-1:0].
  - The counter increments each cycle without ack.
  - On mem_ack: capture rdata lanes and extend (sign from MSB of the selected field if signed, else zero). Go to RESP.
  - If the counter reaches TIMEOUT without ack: drop mem_req. Next cycle pulse exc_valid, code 7, badvaddr = addr. Return to IDLE.
- RESP: rsp_valid=1 for exactly one cycle, rsp_rdata = extended value (0 for stores). Return to IDLE.
  - req_ready stays 0 in RESP; the next accept happens earliest one cycle after the rsp_valid pulse.
- Latency: an aligned access with ack in its first ACCESS cycle gives rsp_valid 2 cycles after accept.
- Flush handling:
  - Flush during ACCESS does not drop mem_req; the bus transaction completes.
  - A flush sets a sticky "killed" flag, which suppresses the following rsp_valid and any DBE exc_valid.
  - Flush in RESP suppresses rsp_valid that cycle.
- exc_valid and rsp_valid are never high together. rsp_rdata and exc_* hold their last values when not pulsing.
- mem_ack outside ACCESS is ignored.
- Reset asserted mid-ACCESS returns to IDLE and drops mem_req immediately.

Decomposition:
- Shared package (ctrl_encode_define): size encodings SZ_BYTE/HALF/WORD/DWORD and exception codes EXC_ADEL=4, EXC_ADES=5, EXC_DBE=7.
- Sub-module load_extend: combinational lane select plus sign/zero extension, parametrised by DATA_W. Inputs data, lane offset, size and signed; output extended value.

Test Plan:
- Aligned LB, DATA_W=32: addr=0x1003, signed, mem_rdata=0x80AABBCC, ack after 1 cycle -> mem_be=4'b1000, mem_addr=0x1000; rsp_rdata=0xFFFFFF80 two cycles after accept. With LBU the result is 0x00000080.
- Aligned SH: addr=0x2002, wdata=0x0000BEEF -> mem_we=1, mem_be=4'b1100, mem_wdata=0xBEEFBEEF; rsp_valid after ack with rsp_rdata=0.
- Misaligned LW at 0x3002 -> exc_valid pulse with code 4 and badvaddr 0x3002; mem_req never asserted. SW at 0x3001 -> code 5.
- Timeout, TIMEOUT=4, mem_ack never asserted -> mem_req held exactly 4 cycles, then exc_code 7 pulse and return to IDLE with req_ready=1.
- Flush during ACCESS, ack 3 cycles later -> mem_req held until ack; no rsp_valid or exc_valid; next request accepted normally.
- DATA_W=64, LD at 0x8 -> mem_be=8'hFF; LD at 0x4 -> AdEL. LW at 0xC, unsigned, rdata=0x89ABCDEF_xxxxxxxx -> rsp_rdata=0x0000000089ABCDEF.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage access unit: access sizes, exception codes,
// FSM states and the alignment rule used at request accept time.
package ctrl_encode_define;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } mau_state_e;

    // dw_ok is low on a 32-bit datapath, where a doubleword can never be aligned.
    function automatic logic misaligned(input logic [2:0] lo, input logic [1:0] size,
                                        input logic dw_ok);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            SZ_WORD: return |lo[1:0];
            default: return (|lo) || !dw_ok;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed field of a memory read word and sign/zero-extends it
// to the full datapath width.
module load_extend
    import ctrl_encode_define::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]            data,
    input  logic [$clog2(DATA_W/8)-1:0]  lane,
    input  logic [1:0]                   size,
    input  logic                         sgn,
    output logic [DATA_W-1:0]            ext
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] word_ext;

    assign shifted = data >> {lane, 3'b000};

    // A word fills the whole datapath when DATA_W is 32, so there is nothing to extend.
    if (DATA_W > 32) begin : g_wide
        assign word_ext = {{(DATA_W-32){sgn & shifted[31]}}, shifted[31:0]};
    end else begin : g_narrow
        assign word_ext = shifted;
    end

    always_comb begin
        ext = shifted;
        case (size)
            SZ_BYTE: ext = {{(DATA_W-8){sgn & shifted[7]}}, shifted[7:0]};
            SZ_HALF: ext = {{(DATA_W-16){sgn & shifted[15]}}, shifted[15:0]};
            SZ_WORD: ext = word_ext;
            default: ext = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: alignment check, word-aligned memory handshake with
// byte enables and timeout, load extension, and flush-aware response/exception pulses.
module mem_access_unit
    import ctrl_encode_define::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic                  flush,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  exc_valid,
    output logic [4:0]            exc_code,
    output logic [ADDR_W-1:0]     exc_badvaddr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);

    mau_state_e        state_reg;
    logic [7:0]        cnt_reg;
    logic              we_reg;
    logic              sgn_reg;
    logic [1:0]        size_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              killed_reg;
    logic              rsp_pend_reg;

    logic              accept;
    logic              req_mis;
    logic [3:0]        lane_w;
    logic [3:0]        nbytes_w;
    logic [NB-1:0]     be_next;
    logic [DATA_W-1:0] wdata_next;
    logic [DATA_W-1:0] ext_data;
    logic              dead;

    assign req_ready = (state_reg == ST_IDLE) && !flush;
    assign rsp_valid = rsp_pend_reg && !flush;
    assign accept    = req_valid && req_ready;
    assign req_mis   = misaligned(req_addr[2:0], req_size, DATA_W == 64);
    assign lane_w    = 4'(req_addr[LB-1:0]);
    assign nbytes_w  = 4'd1 << req_size;
    // A flush in the same cycle as the ack/timeout must already count as killed.
    assign dead      = killed_reg || flush;

    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign be_next[gi] = (4'(gi) >= lane_w) && (4'(gi) < lane_w + nbytes_w);
        assign wdata_next[gi*8 +: 8] =
            (req_size == SZ_BYTE) ? req_wdata[7:0] :
            (req_size == SZ_HALF) ? req_wdata[(gi%2)*8 +: 8] :
            (req_size == SZ_WORD) ? req_wdata[(gi%4)*8 +: 8] :
                                    req_wdata[gi*8 +: 8];
    end

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .data (mem_rdata),
        .lane (addr_reg[LB-1:0]),
        .size (size_reg),
        .sgn  (sgn_reg),
        .ext  (ext_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            we_reg       <= 1'b0;
            sgn_reg      <= 1'b0;
            size_reg     <= '0;
            addr_reg     <= '0;
            killed_reg   <= 1'b0;
            rsp_pend_reg <= 1'b0;
            rsp_rdata    <= '0;
            exc_valid    <= 1'b0;
            exc_code     <= '0;
            exc_badvaddr <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
        end else begin
            exc_valid    <= 1'b0;
            rsp_pend_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        we_reg     <= req_we;
                        sgn_reg    <= req_signed;
                        size_reg   <= req_size;
                        addr_reg   <= req_addr;
                        killed_reg <= 1'b0;
                        cnt_reg    <= '0;
                        if (req_mis) begin
                            exc_valid    <= 1'b1;
                            exc_code     <= req_we ? EXC_ADES : EXC_ADEL;
                            exc_badvaddr <= req_addr;
                        end else begin
                            state_reg <= ST_ACCESS;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[ADDR_W-1:LB], {LB{1'b0}}};
                            mem_be    <= be_next;
                            mem_wdata <= wdata_next;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (flush) begin
                        killed_reg <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        state_reg <= ST_RESP;
                        if (!dead) begin
                            rsp_pend_reg <= 1'b1;
                            rsp_rdata    <= we_reg ? '0 : ext_data;
                        end
                    end else if (cnt_reg == 8'(TIMEOUT - 1)) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        state_reg <= ST_IDLE;
                        if (!dead) begin
                            exc_valid    <= 1'b1;
                            exc_code     <= EXC_DBE;
                            exc_badvaddr <= addr_reg;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised and directed bench for mem_access_unit on a 32-bit and a 64-bit
// instance, checked against an arithmetic model of the access rules.
module tb_mem_access_unit;

    localparam int TO32 = 4;
    localparam int TO64 = 5;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, flush, sel64;
    logic        req_valid, req_we, req_signed, mem_ack;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, mem_rdata;

    logic        ready32, rspv32, excv32, mreq32, mwe32;
    logic [31:0] rdata32, bad32, maddr32, mwdata32;
    logic [4:0]  code32;
    logic [3:0]  be32;
    logic        ready64, rspv64, excv64, mreq64, mwe64;
    logic [63:0] rdata64, mwdata64;
    logic [31:0] bad64, maddr64;
    logic [4:0]  code64;
    logic [7:0]  be64;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO32)) u_dut32 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid && !sel64), .req_ready(ready32),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .flush(flush), .rsp_valid(rspv32), .rsp_rdata(rdata32),
        .exc_valid(excv32), .exc_code(code32), .exc_badvaddr(bad32), .mem_req(mreq32),
        .mem_we(mwe32), .mem_addr(maddr32), .mem_be(be32), .mem_wdata(mwdata32),
        .mem_ack(mem_ack && !sel64), .mem_rdata(mem_rdata[31:0])
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO64)) u_dut64 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid && sel64), .req_ready(ready64),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .flush(flush), .rsp_valid(rspv64), .rsp_rdata(rdata64),
        .exc_valid(excv64), .exc_code(code64), .exc_badvaddr(bad64), .mem_req(mreq64),
        .mem_we(mwe64), .mem_addr(maddr64), .mem_be(be64), .mem_wdata(mwdata64),
        .mem_ack(mem_ack && sel64), .mem_rdata(mem_rdata)
    );

    logic        o_ready, o_rspv, o_excv, o_mreq, o_mwe;
    logic [63:0] o_rdata, o_bad, o_maddr, o_be, o_mwdata, o_code;

    always_comb begin
        if (sel64) begin
            o_ready = ready64; o_rspv = rspv64; o_excv = excv64; o_mreq = mreq64; o_mwe = mwe64;
            o_rdata = rdata64; o_bad = 64'(bad64); o_maddr = 64'(maddr64);
            o_be = 64'(be64); o_mwdata = mwdata64; o_code = 64'(code64);
        end else begin
            o_ready = ready32; o_rspv = rspv32; o_excv = excv32; o_mreq = mreq32; o_mwe = mwe32;
            o_rdata = 64'(rdata32); o_bad = 64'(bad32); o_maddr = 64'(maddr32);
            o_be = 64'(be32); o_mwdata = 64'(mwdata32); o_code = 64'(code32);
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference load result: pick the addressed bytes, then extend by plain masking.
    function automatic logic [63:0] ext_model(input logic [63:0] rd, input int lane,
                                              input int nbytes, input bit sgn, input int dw);
        logic [63:0] v, m;
        if (dw == 32) rd = rd & 64'hFFFF_FFFF;
        v = rd >> (8 * lane);
        m = (nbytes == 8) ? '1 : ((64'd1 << (8 * nbytes)) - 64'd1);
        v = v & m;
        if (sgn && v[8*nbytes-1]) v = v | ~m;
        if (dw == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    // ack_dly: ACCESS cycle index carrying mem_ack (>= timeout means never).
    // flush_at: ACCESS cycle index with flush, ack_dly+1 means the RESP cycle, -1 none.
    task automatic run_access(input bit s64, input bit we, input logic [1:0] size, input bit sgn,
                              input logic [31:0] addr, input logic [63:0] wd,
                              input logic [63:0] rd, input int ack_dly, input int flush_at);
        int dw, nb, to, nbytes, lane;
        bit mis, killed, acked, flush_resp;
        logic [63:0] exp_wd;
        dw = s64 ? 64 : 32;
        nb = dw / 8;
        to = s64 ? TO64 : TO32;
        nbytes = 1 << size;
        lane = int'(addr) % nb;
        mis = ((int'(addr) % nbytes) != 0) || (size == 2'd3 && dw == 32);
        killed = 1'b0;
        acked = 1'b0;
        exp_wd = '0;

        @(negedge clk);
        flush = 1'b0; mem_ack = 1'b0; sel64 = s64;
        #1;
        check_eq("idle_ready", 64'(o_ready), 64'd1);
        check_eq("idle_quiet", 64'({o_rspv, o_excv, o_mreq}), 64'd0);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wd; mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        req_valid = 1'b0; mem_ack = 1'b0;
        req_addr = $urandom; req_wdata = {$urandom, $urandom};

        if (mis) begin
            check_eq("exc_valid", 64'(o_excv), 64'd1);
            check_eq("exc_code", o_code, we ? 64'd5 : 64'd4);
            check_eq("exc_badvaddr", o_bad, 64'(addr));
            check_eq("mis_no_memreq", 64'(o_mreq), 64'd0);
            check_eq("mis_no_rsp", 64'(o_rspv), 64'd0);
            $display("vec %0d: dw%0d %s sz%0d @%h misaligned", n_vec, dw, we ? "ST" : "LD", size, addr);
            return;
        end

        for (int i = 0; i < nb; i++) exp_wd[8*i +: 8] = wd[8*(i % nbytes) +: 8];
        check_eq("mem_we", 64'(o_mwe), 64'(we));
        check_eq("mem_be", o_be, 64'(((1 << nbytes) - 1) << lane));
        if (we) check_eq("mem_wdata", o_mwdata, exp_wd);

        for (int k = 0; k < to; k++) begin
            check_eq("mem_req_held", 64'(o_mreq), 64'd1);
            check_eq("mem_addr", o_maddr, 64'(addr) - 64'(lane));
            check_eq("access_no_exc", 64'(o_excv), 64'd0);
            mem_ack = (k == ack_dly);
            flush = (k == flush_at);
            mem_rdata = rd;
            if (flush) killed = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0; flush = 1'b0; mem_rdata = {$urandom, $urandom};
            if (k == ack_dly) begin
                acked = 1'b1;
                break;
            end
        end

        if (acked) begin
            flush_resp = (flush_at == ack_dly + 1);
            flush = flush_resp;
            #1;
            check_eq("rsp_valid", 64'(o_rspv), 64'(!killed && !flush_resp));
            check_eq("rsp_no_exc", 64'(o_excv), 64'd0);
            check_eq("resp_not_ready", 64'(o_ready), 64'd0);
            check_eq("mem_req_dropped", 64'(o_mreq), 64'd0);
            if (!killed) check_eq("rsp_rdata", o_rdata, we ? 64'd0 : ext_model(rd, lane, nbytes, sgn, dw));
        end else begin
            #1;
            check_eq("to_mem_req", 64'(o_mreq), 64'd0);
            check_eq("to_exc_valid", 64'(o_excv), 64'(!killed));
            if (!killed) begin
                check_eq("to_exc_code", o_code, 64'd7);
                check_eq("to_badvaddr", o_bad, 64'(addr));
            end
            check_eq("to_ready", 64'(o_ready), 64'd1);
        end
        $display("vec %0d: dw%0d %s sz%0d s%0d @%h ack%0d flush%0d -> rdata %h", n_vec, dw,
                 we ? "ST" : "LD", size, sgn, addr, ack_dly, flush_at, o_rdata);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int dly, fat, s64v, to;
        rstn = 1'b0; flush = 1'b0; sel64 = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_size = '0; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_ready", 64'(o_ready), 64'd1);
        check_eq("rst_flags", 64'({o_rspv, o_excv, o_mreq, o_mwe}), 64'd0);
        check_eq("rst_rdata", o_rdata, 64'd0);
        check_eq("rst_be", o_be, 64'd0);
        check_eq("rst_code", o_code, 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        run_access(0, 0, 2'd0, 1, 32'h1003, 64'h0, 64'h80AABBCC, 0, -1);
        check_eq("lb_signed", o_rdata, 64'hFFFF_FF80);
        run_access(0, 0, 2'd0, 0, 32'h1003, 64'h0, 64'h80AABBCC, 0, -1);
        check_eq("lbu", o_rdata, 64'h0000_0080);
        run_access(0, 1, 2'd1, 0, 32'h2002, 64'hBEEF, 64'h12345678, 0, -1);
        run_access(0, 0, 2'd2, 0, 32'h3002, 64'h0, 64'h0, 0, -1);
        run_access(0, 1, 2'd2, 0, 32'h3001, 64'h0, 64'h0, 0, -1);
        run_access(0, 0, 2'd2, 0, 32'h4000, 64'h0, 64'h0, 99, -1);
        run_access(0, 0, 2'd2, 0, 32'h5000, 64'h0, 64'hCAFEF00D, 3, 0);
        run_access(0, 0, 2'd2, 1, 32'h5004, 64'h0, 64'h8000_0001, 0, 1);
        run_access(0, 0, 2'd1, 1, 32'h6002, 64'h0, 64'h9234_5678, 1, -1);
        run_access(1, 0, 2'd3, 0, 32'h0008, 64'h0, 64'h0123_4567_89AB_CDEF, 0, -1);
        run_access(1, 0, 2'd3, 0, 32'h0004, 64'h0, 64'h0, 0, -1);
        run_access(1, 0, 2'd2, 0, 32'h000C, 64'h0, 64'h89AB_CDEF_1234_5678, 0, -1);
        check_eq("lw64_hi", o_rdata, 64'h0000_0000_89AB_CDEF);
        run_access(1, 1, 2'd0, 0, 32'h0015, 64'h5A, 64'h0, 2, -1);

        for (int n = 0; n < 160; n++) begin
            s64v = $urandom_range(0, 1);
            to = s64v ? TO64 : TO32;
            dly = ($urandom_range(0, 4) == 0) ? 99 : $urandom_range(0, to - 1);
            fat = ($urandom_range(0, 4) == 0) ? $urandom_range(0, (dly < to) ? dly + 1 : to - 1) : -1;
            run_access(s64v[0], 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), {$urandom_range(0, 255), 3'($urandom_range(0, 7))},
                       {$urandom, $urandom}, {$urandom, $urandom}, dly, fat);
        end

        // Asynchronous reset while the memory request is outstanding.
        @(negedge clk);
        sel64 = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h40;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("pre_rst_memreq", 64'(o_mreq), 64'd1);
        rstn = 1'b0;
        #1;
        check_eq("async_rst_memreq", 64'(o_mreq), 64'd0);
        check_eq("async_rst_ready", 64'(o_ready), 64'd1);
        @(negedge clk);
        rstn = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
